nfu3_ctrl: RTL and testbench
============================

# nfu3_ctrl

Sequencer for the isolated NFU-3 stage. It loads the sigmoid coefficient table at the start of a layer. It then accepts NFU-2 result beats and counts input iterations per output tile. It drives the NBout path select and issues NBout write strobes aligned to the NFU-3 pipeline, stalling NFU-2 while a final (sigmoid) result is in flight.

## Interface
Parameters:
- BIT_WIDTH, 16, datapath element width
- NUM_SEG, 16, sigmoid segments (Ai/Bi pairs) loaded per layer
- CNT_W, 16, width of iteration/tile counters
- NFU3_LAT, 2, cycles from NFU-3 input register valid to NFU-3 output register valid (≥1)

Ports:
- clk  in  1  clock; rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- i_cfg_start  in  1  layer start pulse; sampled only in IDLE
- i_cfg_num_in_iter  in  CNT_W  NFU-2 beats per output tile; 0 treated as 1
- i_cfg_num_out_tiles  in  CNT_W  output tiles in layer
- i_coef_valid  in  1  coefficient beat valid
- i_coef_data  in  2*BIT_WIDTH  {Ai,Bi} pair
- o_coef_ready  out  1  coefficient beat accepted when valid&ready
- o_sigmoid_coef  out  2*BIT_WIDTH  registered coefficient to NFU-3
- o_load_sigmoid_coef  out  1  coefficient write strobe to NFU-3
- i_nfu2_valid  in  1  NFU-2 result beat valid
- o_nfu2_ready  out  1  beat accepted when valid&ready
- o_nbout_nfu2_nfu3  out  1  1 = partial sum path, 0 = NFU-3 path
- o_nbout_wr_en  out  1  NBout write strobe
- o_nbout_tile  out  CNT_W  output tile index of current write
- o_busy  out  1  not IDLE
- o_done  out  1  one-cycle layer-complete pulse

## Operation
- States: IDLE, LOAD, RUN, WAIT_FINAL, DONE.
- IDLE: i_cfg_start latches both config values, clears counters → LOAD.
- LOAD: o_coef_ready=1. Each accepted beat registers data to o_sigmoid_coef and pulses o_load_sigmoid_coef in the next cycle. After NUM_SEG beats: → DONE if num_out_tiles==0, else → RUN.
- RUN: o_nfu2_ready=1. in_cnt counts accepted beats 0..num_in_iter-1.
  - Beat with in_cnt < last: partial write. in_cnt increments.
  - Beat with in_cnt == last: final write. in_cnt clears and the state goes → WAIT_FINAL.
- WAIT_FINAL: o_nfu2_ready=0 until the final write issues. Then tile_cnt increments. If the tile was the last one → DONE, else → RUN.
- DONE: o_done=1 for one cycle → IDLE.
- Write tracking is a NFU3_LAT+1 deep shift register of {valid, final, tile}. o_nbout_tile carries the tile of the beat being written.
- Ignored inputs:
  - i_cfg_start outside IDLE.
  - i_coef_valid outside LOAD (o_coef_ready=0).
  - i_nfu2_valid outside RUN.
- Counters wrap at 2^CNT_W. Config ranges above that are unsupported.

## Timing
- Reset values: o_coef_ready=0, o_load_sigmoid_coef=0, o_sigmoid_coef=0, o_nfu2_ready=0, o_nbout_nfu2_nfu3=1, o_nbout_wr_en=0, o_nbout_tile=0, o_busy=0, o_done=0. State returns to IDLE.
- Reset mid-operation clears the tracker pipeline; no write strobe follows reset.
- Coefficient beat accepted at edge T: o_load_sigmoid_coef high during cycle T+1 with its data. Back-to-back beats give back-to-back strobes.
- Partial beat accepted at edge T: o_nbout_wr_en=1 with o_nbout_nfu2_nfu3=1 during cycle T+1.
- Final beat accepted at edge T:
  - o_nfu2_ready=0 during cycles T+1..T+1+NFU3_LAT.
  - o_nbout_wr_en=1 with o_nbout_nfu2_nfu3=0 during cycle T+1+NFU3_LAT.
  - o_nbout_nfu2_nfu3 is 1 in every other cycle.
  - If more tiles remain, o_nfu2_ready=1 again in cycle T+2+NFU3_LAT.
- A partial write and a final write never share a cycle (guaranteed by the stall).
- Last final write in cycle W: o_done=1 in cycle W+1, o_busy=0 from W+2.
- o_busy=1 from the cycle after the start pulse through the DONE cycle.

## Structure
- Package nfu3_ctrl_pkg:
  - state enum (IDLE, LOAD, RUN, WAIT_FINAL, DONE)
  - default widths
  - tracker entry typedef {valid, final, tile}
- One sub-module, nfu3_wr_tracker: parameterised shift register producing wr_en, the path select and the tile index.

## Test plan
- Coefficient load: start with NUM_SEG=16; 16 beats with valid held high, data=i → 16 consecutive strobes with o_sigmoid_coef=0..15, first strobe in the cycle after the first accept, then RUN.
- Mixed tile: num_in_iter=4, num_out_tiles=1, NFU3_LAT=2, valid continuous.
  - 3 partial writes (select=1), one per cycle.
  - Final write (select=0, tile=0) 3 cycles after the 4th accept.
  - o_done one cycle later.
- Multi-tile stall: num_in_iter=1, num_out_tiles=3, valid continuous.
  - Ready shows pattern 1,0,0,0 repeating.
  - Writes carry tile 0,1,2.
  - Exactly 3 strobes, all with select=0.
- Zero-iteration/zero-tile configs:
  - num_in_iter=0 behaves as 1.
  - num_out_tiles=0 → DONE right after LOAD with no NBout writes.
- Ignored inputs: i_cfg_start asserted during RUN, and i_coef_valid asserted during RUN → no state change, no coefficient strobe.
- Async reset asserted during WAIT_FINAL → all outputs at reset values immediately, no pending write after deassert, next start behaves normally.

Source files
------------

// File: rtl/nfu3_ctrl_pkg.sv
// Shared types and default widths for the NFU-3 sequencer and its write tracker.
package nfu3_ctrl_pkg;

    localparam int DEF_BIT_WIDTH = 16;
    localparam int DEF_NUM_SEG   = 16;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_NFU3_LAT  = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        WAIT_FINAL,
        DONE
    } state_t;

    // Tracker entry flags; the tile index rides alongside in a CNT_W-wide pipe.
    typedef struct packed {
        logic valid;
        logic fin;
    } trk_flags_t;

endpackage

// File: rtl/nfu3_wr_tracker.sv
// Shift register following accepted NFU-2 beats down the NFU-3 pipeline and
// producing the NBout write strobe, path select and tile index.
module nfu3_wr_tracker
    import nfu3_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int LAT   = DEF_NFU3_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             push_final,
    input  logic [CNT_W-1:0] push_tile,
    output logic             wr_en,
    output logic             path_sel,
    output logic [CNT_W-1:0] wr_tile
);

    trk_flags_t       vld_pipe  [LAT:0];
    logic [CNT_W-1:0] tile_pipe [LAT:0];
    logic             part_wr;
    logic             fin_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= LAT; i++) begin
                vld_pipe[i]  <= '0;
                tile_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0]  <= '{valid: push, fin: push & push_final};
            tile_pipe[0] <= push_tile;
            for (int i = 1; i <= LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                tile_pipe[i] <= tile_pipe[i-1];
            end
        end
    end

    // Partials bypass NFU-3 and write from stage 0; finals write after the full latency.
    assign part_wr  = vld_pipe[0].valid & ~vld_pipe[0].fin;
    assign fin_wr   = vld_pipe[LAT].valid & vld_pipe[LAT].fin;
    assign wr_en    = part_wr | fin_wr;
    assign path_sel = ~fin_wr;
    assign wr_tile  = fin_wr  ? tile_pipe[LAT] :
                      part_wr ? tile_pipe[0]   : '0;

endmodule

// File: rtl/nfu3_ctrl.sv
// NFU-3 stage sequencer: sigmoid coefficient load, NFU-2 beat counting per tile,
// NBout write sequencing with a stall while the final (sigmoid) result is in flight.
module nfu3_ctrl
    import nfu3_ctrl_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int NUM_SEG   = DEF_NUM_SEG,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int NFU3_LAT  = DEF_NFU3_LAT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_cfg_start,
    input  logic [CNT_W-1:0]       i_cfg_num_in_iter,
    input  logic [CNT_W-1:0]       i_cfg_num_out_tiles,
    input  logic                   i_coef_valid,
    input  logic [2*BIT_WIDTH-1:0] i_coef_data,
    output logic                   o_coef_ready,
    output logic [2*BIT_WIDTH-1:0] o_sigmoid_coef,
    output logic                   o_load_sigmoid_coef,
    input  logic                   i_nfu2_valid,
    output logic                   o_nfu2_ready,
    output logic                   o_nbout_nfu2_nfu3,
    output logic                   o_nbout_wr_en,
    output logic [CNT_W-1:0]       o_nbout_tile,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int SEG_W = $clog2(NUM_SEG + 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] in_last, tiles_q, in_cnt, tile_cnt;
    logic [SEG_W-1:0] seg_cnt;
    logic             coef_acc, nfu2_acc, seg_last, beat_last, tile_last, fin_wr;

    assign o_coef_ready = (state == LOAD);
    assign o_nfu2_ready = (state == RUN);
    assign o_busy       = (state != IDLE);
    assign o_done       = (state == DONE);

    assign coef_acc  = i_coef_valid & o_coef_ready;
    assign nfu2_acc  = i_nfu2_valid & o_nfu2_ready;
    assign seg_last  = (seg_cnt == SEG_W'(NUM_SEG - 1));
    assign beat_last = (in_cnt == in_last);
    assign tile_last = (tile_cnt == tiles_q - CNT_W'(1));
    assign fin_wr    = o_nbout_wr_en & ~o_nbout_nfu2_nfu3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (i_cfg_start) state_nxt = LOAD;
            LOAD:       if (coef_acc && seg_last)
                            state_nxt = (tiles_q == '0) ? DONE : RUN;
            RUN:        if (nfu2_acc && beat_last) state_nxt = WAIT_FINAL;
            WAIT_FINAL: if (fin_wr) state_nxt = tile_last ? DONE : RUN;
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_last  <= '0;
            tiles_q  <= '0;
            in_cnt   <= '0;
            tile_cnt <= '0;
            seg_cnt  <= '0;
        end else begin
            if (state == IDLE && i_cfg_start) begin
                // A zero beat count collapses to one beat per tile.
                in_last  <= (i_cfg_num_in_iter == '0) ? '0 : i_cfg_num_in_iter - CNT_W'(1);
                tiles_q  <= i_cfg_num_out_tiles;
                in_cnt   <= '0;
                tile_cnt <= '0;
                seg_cnt  <= '0;
            end
            if (coef_acc) seg_cnt <= seg_cnt + SEG_W'(1);
            if (nfu2_acc) in_cnt  <= beat_last ? '0 : in_cnt + CNT_W'(1);
            if (state == WAIT_FINAL && fin_wr) tile_cnt <= tile_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_load_sigmoid_coef <= 1'b0;
            o_sigmoid_coef      <= '0;
        end else begin
            o_load_sigmoid_coef <= coef_acc;
            if (coef_acc) o_sigmoid_coef <= i_coef_data;
        end
    end

    nfu3_wr_tracker #(
        .CNT_W (CNT_W),
        .LAT   (NFU3_LAT)
    ) u_trk (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (nfu2_acc),
        .push_final (beat_last),
        .push_tile  (tile_cnt),
        .wr_en      (o_nbout_wr_en),
        .path_sel   (o_nbout_nfu2_nfu3),
        .wr_tile    (o_nbout_tile)
    );

endmodule

// File: tb/tb_nfu3_ctrl.sv
// Scoreboard bench for nfu3_ctrl: expected coefficient strobes and NBout writes are
// queued when beats are driven and popped when the DUT produces them.
module tb_nfu3_ctrl;

    localparam int BW   = 16;
    localparam int NSEG = 16;
    localparam int CW   = 16;
    localparam int LAT  = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            i_cfg_start;
    logic [CW-1:0]   i_cfg_num_in_iter, i_cfg_num_out_tiles;
    logic            i_coef_valid;
    logic [2*BW-1:0] i_coef_data;
    logic            o_coef_ready;
    logic [2*BW-1:0] o_sigmoid_coef;
    logic            o_load_sigmoid_coef;
    logic            i_nfu2_valid;
    logic            o_nfu2_ready, o_nbout_nfu2_nfu3, o_nbout_wr_en, o_busy, o_done;
    logic [CW-1:0]   o_nbout_tile;

    nfu3_ctrl #(.BIT_WIDTH(BW), .NUM_SEG(NSEG), .CNT_W(CW), .NFU3_LAT(LAT)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_cfg_start         (i_cfg_start),
        .i_cfg_num_in_iter   (i_cfg_num_in_iter),
        .i_cfg_num_out_tiles (i_cfg_num_out_tiles),
        .i_coef_valid        (i_coef_valid),
        .i_coef_data         (i_coef_data),
        .o_coef_ready        (o_coef_ready),
        .o_sigmoid_coef      (o_sigmoid_coef),
        .o_load_sigmoid_coef (o_load_sigmoid_coef),
        .i_nfu2_valid        (i_nfu2_valid),
        .o_nfu2_ready        (o_nfu2_ready),
        .o_nbout_nfu2_nfu3   (o_nbout_nfu2_nfu3),
        .o_nbout_wr_en       (o_nbout_wr_en),
        .o_nbout_tile        (o_nbout_tile),
        .o_busy              (o_busy),
        .o_done              (o_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [2*BW-1:0] exp_coef[$];
    logic [CW:0]     exp_wr[$];
    int wr_log[$];
    bit rdy_log[$];
    int wr_count = 0, last_wr_cyc = 0, done_cyc = 0, acc_first = 0, acc_last = 0;
    bit done_flag = 0;

    always @(posedge clk) cyc++;

    // Scoreboard side: pop and compare whatever the DUT emits this cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_load_sigmoid_coef) begin
                total++;
                if (exp_coef.size() == 0) begin
                    bad++;
                    $display("FAIL coef_unexpected got=%h expected no strobe", o_sigmoid_coef);
                end else begin
                    logic [2*BW-1:0] e;
                    e = exp_coef.pop_front();
                    if (o_sigmoid_coef !== e) begin
                        bad++;
                        $display("FAIL coef_data got=%h exp=%h", o_sigmoid_coef, e);
                    end
                end
            end
            if (o_nbout_wr_en) begin
                wr_count++;
                wr_log.push_back(cyc);
                last_wr_cyc = cyc;
                total++;
                if (exp_wr.size() == 0) begin
                    bad++;
                    $display("FAIL wr_unexpected sel=%0b tile=%0d at cyc %0d", o_nbout_nfu2_nfu3, o_nbout_tile, cyc);
                end else begin
                    logic [CW:0] w;
                    w = exp_wr.pop_front();
                    if ({o_nbout_nfu2_nfu3, o_nbout_tile} !== w) begin
                        bad++;
                        $display("FAIL wr_data got sel=%0b tile=%0d exp sel=%0b tile=%0d", o_nbout_nfu2_nfu3, o_nbout_tile, w[CW], w[CW-1:0]);
                    end
                end
            end else begin
                total++;
                if (o_nbout_nfu2_nfu3 !== 1'b1) begin
                    bad++;
                    $display("FAIL sel_idle got=%0b exp=1 at cyc %0d", o_nbout_nfu2_nfu3, cyc);
                end
            end
            if (o_done) begin
                done_flag = 1;
                done_cyc = cyc;
            end
        end
    end

    task automatic start_layer(input int iter, input int tiles);
        i_cfg_num_in_iter   = CW'(iter);
        i_cfg_num_out_tiles = CW'(tiles);
        i_cfg_start = 1;
        done_flag = 0;
        wr_count = 0;
        wr_log.delete();
        rdy_log.delete();
        @(posedge clk); #1;
        i_cfg_start = 0;
    endtask

    task automatic load_coefs(input int base);
        i_coef_valid = 1;
        for (int i = 0; i < NSEG; i++) begin
            i_coef_data = (2*BW)'(base + i);
            exp_coef.push_back((2*BW)'(base + i));
            @(posedge clk); #1;
        end
        i_coef_valid = 0;
    endtask

    task automatic drive_beats(input int iter, input int tiles);
        int ie = (iter == 0) ? 1 : iter;
        int b = 0;
        int t = 0;
        int guard = 0;
        bit fin;
        i_nfu2_valid = 1;
        while (t < tiles && guard < 1000) begin
            rdy_log.push_back(o_nfu2_ready);
            if (o_nfu2_ready) begin
                fin = (b == ie - 1);
                exp_wr.push_back({~fin, CW'(t)});
                if (t == 0 && b == 0) acc_first = cyc;
                acc_last = cyc;
                if (fin) begin b = 0; t++; end
                else b++;
            end
            @(posedge clk); #1;
            guard++;
        end
        i_nfu2_valid = 0;
        total++;
        if (guard >= 1000) begin
            bad++;
            $display("FAIL beats_timeout tiles_done=%0d exp=%0d", t, tiles);
        end
    endtask

    task automatic wait_done(output bit ok);
        int k = 0;
        while (!done_flag && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        ok = done_flag;
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({o_coef_ready, o_load_sigmoid_coef, o_nfu2_ready, o_nbout_nfu2_nfu3, o_nbout_wr_en, o_busy, o_done} !== 7'b0001000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=0001000", {o_coef_ready, o_load_sigmoid_coef, o_nfu2_ready, o_nbout_nfu2_nfu3, o_nbout_wr_en, o_busy, o_done});
        end
        total++;
        if (o_sigmoid_coef !== '0) begin bad++; $display("FAIL reset_coef got=%h exp=0", o_sigmoid_coef); end
        total++;
        if (o_nbout_tile !== '0) begin bad++; $display("FAIL reset_tile got=%0d exp=0", o_nbout_tile); end
        rst_n = 1;
        @(posedge clk); #1;
        total++;
        if (o_busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset busy=%0b exp=0", o_busy); end
    endtask

    task automatic test_coef_load;
        bit ok;
        start_layer(1, 1);
        total++;
        if (o_busy !== 1'b1) begin bad++; $display("FAIL busy_after_start got=%0b exp=1", o_busy); end
        total++;
        if (o_load_sigmoid_coef !== 1'b0) begin bad++; $display("FAIL strobe_early got=%0b exp=0", o_load_sigmoid_coef); end
        i_coef_valid = 1;
        for (int i = 0; i < NSEG; i++) begin
            i_coef_data = (2*BW)'(i);
            exp_coef.push_back((2*BW)'(i));
            @(posedge clk); #1;
            total++;
            if (o_load_sigmoid_coef !== 1'b1) begin bad++; $display("FAIL strobe_%0d got=%0b exp=1", i, o_load_sigmoid_coef); end
        end
        i_coef_valid = 0;
        total++;
        if (o_nfu2_ready !== 1'b1 || o_coef_ready !== 1'b0) begin
            bad++;
            $display("FAIL run_after_load nfu2_ready=%0b coef_ready=%0b exp 1/0", o_nfu2_ready, o_coef_ready);
        end
        drive_beats(1, 1);
        wait_done(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL coef_layer_done_timeout got=0 exp=1"); end
    endtask

    task automatic test_mixed_tile;
        bit ok;
        start_layer(4, 1);
        load_coefs(100);
        drive_beats(4, 1);
        wait_done(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL mixed_done_timeout got=0 exp=1"); end
        total++;
        if (wr_count !== 4) begin bad++; $display("FAIL mixed_wr_count got=%0d exp=4", wr_count); end
        if (wr_log.size() == 4) begin
            total++;
            if (wr_log[0] !== acc_first + 1 || wr_log[2] !== acc_first + 3) begin
                bad++;
                $display("FAIL mixed_partial_cycles got=%0d,%0d exp=%0d,%0d", wr_log[0], wr_log[2], acc_first + 1, acc_first + 3);
            end
        end
        total++;
        if (last_wr_cyc !== acc_last + 1 + LAT) begin
            bad++;
            $display("FAIL mixed_final_cycle got=%0d exp=%0d", last_wr_cyc, acc_last + 1 + LAT);
        end
        total++;
        if (done_cyc !== last_wr_cyc + 1) begin bad++; $display("FAIL mixed_done_cycle got=%0d exp=%0d", done_cyc, last_wr_cyc + 1); end
        total++;
        if (o_busy !== 1'b0) begin bad++; $display("FAIL mixed_busy_after got=%0b exp=0", o_busy); end
    endtask

    task automatic test_multi_tile;
        bit ok;
        bit exp_rdy [8] = '{1, 0, 0, 0, 1, 0, 0, 0};
        start_layer(1, 3);
        load_coefs(300);
        drive_beats(1, 3);
        wait_done(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL multi_done_timeout got=0 exp=1"); end
        total++;
        if (rdy_log.size() < 8) begin
            bad++;
            $display("FAIL multi_ready_len got=%0d exp>=8", rdy_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (rdy_log[i] !== exp_rdy[i]) begin
                    bad++;
                    $display("FAIL multi_ready_%0d got=%0b exp=%0b", i, rdy_log[i], exp_rdy[i]);
                    break;
                end
            end
        end
        total++;
        if (wr_count !== 3) begin bad++; $display("FAIL multi_wr_count got=%0d exp=3", wr_count); end
        total++;
        if (done_cyc !== last_wr_cyc + 1) begin bad++; $display("FAIL multi_done_cycle got=%0d exp=%0d", done_cyc, last_wr_cyc + 1); end
    endtask

    task automatic test_zero_cfg;
        bit ok;
        start_layer(0, 2);
        load_coefs(400);
        drive_beats(0, 2);
        wait_done(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL zero_iter_done_timeout got=0 exp=1"); end
        total++;
        if (wr_count !== 2) begin bad++; $display("FAIL zero_iter_wr_count got=%0d exp=2", wr_count); end
        start_layer(3, 0);
        load_coefs(500);
        total++;
        if (o_done !== 1'b1 || o_nfu2_ready !== 1'b0) begin
            bad++;
            $display("FAIL zero_tile_done got done=%0b ready=%0b exp 1/0", o_done, o_nfu2_ready);
        end
        @(posedge clk); #1;
        total++;
        if (o_busy !== 1'b0) begin bad++; $display("FAIL zero_tile_idle busy=%0b exp=0", o_busy); end
        total++;
        if (wr_count !== 0) begin bad++; $display("FAIL zero_tile_wr_count got=%0d exp=0", wr_count); end
    endtask

    task automatic test_ignored;
        bit ok;
        start_layer(2, 2);
        load_coefs(600);
        total++;
        if (o_coef_ready !== 1'b0) begin bad++; $display("FAIL ign_coef_ready got=%0b exp=0", o_coef_ready); end
        // Hold start and a coefficient beat with a different config through RUN.
        i_cfg_start = 1;
        i_cfg_num_in_iter = CW'(7);
        i_coef_valid = 1;
        i_coef_data = '1;
        drive_beats(2, 2);
        i_cfg_start = 0;
        i_coef_valid = 0;
        wait_done(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL ign_done_timeout got=0 exp=1"); end
        total++;
        if (wr_count !== 4) begin bad++; $display("FAIL ign_wr_count got=%0d exp=4", wr_count); end
    endtask

    task automatic test_reset_wait_final;
        bit ok;
        start_layer(1, 2);
        load_coefs(700);
        i_nfu2_valid = 1;
        @(posedge clk); #1;
        i_nfu2_valid = 0;
        total++;
        if (o_nfu2_ready !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b exp=0", o_nfu2_ready); end
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        total++;
        if ({o_coef_ready, o_load_sigmoid_coef, o_nfu2_ready, o_nbout_nfu2_nfu3, o_nbout_wr_en, o_busy, o_done} !== 7'b0001000) begin
            bad++;
            $display("FAIL rst_mid_ctrl got=%b exp=0001000", {o_coef_ready, o_load_sigmoid_coef, o_nfu2_ready, o_nbout_nfu2_nfu3, o_nbout_wr_en, o_busy, o_done});
        end
        total++;
        if (o_sigmoid_coef !== '0 || o_nbout_tile !== '0) begin
            bad++;
            $display("FAIL rst_mid_data coef=%h tile=%0d exp 0/0", o_sigmoid_coef, o_nbout_tile);
        end
        @(posedge clk); #1;
        rst_n = 1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            total++;
            if (o_nbout_wr_en !== 1'b0) begin bad++; $display("FAIL rst_pending_wr k=%0d got=1 exp=0", k); end
        end
        start_layer(2, 1);
        load_coefs(800);
        drive_beats(2, 1);
        wait_done(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL post_rst_done_timeout got=0 exp=1"); end
        total++;
        if (wr_count !== 2) begin bad++; $display("FAIL post_rst_wr_count got=%0d exp=2", wr_count); end
    endtask

    initial begin
        i_cfg_start = 0;
        i_cfg_num_in_iter = '0;
        i_cfg_num_out_tiles = '0;
        i_coef_valid = 0;
        i_coef_data = '0;
        i_nfu2_valid = 0;
        test_reset;
        test_coef_load;
        test_mixed_tile;
        test_multi_tile;
        test_zero_cfg;
        test_ignored;
        test_reset_wait_final;
        total++;
        if (exp_wr.size() != 0 || exp_coef.size() != 0) begin
            bad++;
            $display("FAIL leftover wr=%0d coef=%0d exp 0/0", exp_wr.size(), exp_coef.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
